rob_commit_ctrl: RTL

//  Owns the 64-entry reorder buffer: allocates up to 4 entries/cycle at the tail for decode,

---
 rtl/rob_commit_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit_ctrl
// Desc     : 64-entry reorder buffer with 4-wide allocate, 4-bus completion and
//            2-wide in-order retire onto the register-file write ports.
//            Optional macro COMMIT_STATS_EN adds the retired_total counter.
// Revision : 1.0 - initial release
// ============================================================================
module rob_commit_ctrl #(
    parameter int DEPTH  = 64,
    parameter int PTR_W  = 6,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                alloc_req,
    input  logic [3:0]                alloc_wen,
    input  logic [11:0]               alloc_wreg,
    input  logic [4*DATA_W-1:0]       alloc_pc,
    output logic                      alloc_grant,
    output logic [PTR_W-1:0]          alloc_base,
    input  logic [PTR_W+DATA_W:0]     fwd_a,
    input  logic [PTR_W+DATA_W:0]     fwd_b,
    input  logic [PTR_W+DATA_W:0]     fwd_c,
    input  logic [PTR_W+DATA_W:0]     fwd_d,
    input  logic                      flush,
    output logic                      wen0,
    output logic                      wen1,
    output logic [2:0]                waddr0,
    output logic [2:0]                waddr1,
    output logic [DATA_W-1:0]         wdata0,
    output logic [DATA_W-1:0]         wdata1,
    output logic [DATA_W-1:0]         commit_pc,
    output logic [PTR_W:0]            rob_count,
    output logic                      rob_empty
`ifdef COMMIT_STATS_EN
    ,
    output logic [31:0]               retired_total
`endif
);

    localparam int              c_SLOTS = 4;
    localparam int              c_FWD_W = PTR_W + DATA_W + 1;
    localparam logic [PTR_W:0]  c_DEPTH = (PTR_W+1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_ready;
    logic [DEPTH-1:0]  r_ent_wen;
    logic [2:0]        r_ent_wreg  [DEPTH];
    logic [DATA_W-1:0] r_ent_value [DEPTH];
    logic [DATA_W-1:0] r_ent_pc    [DEPTH];

    logic              r_wen0;
    logic              r_wen1;
    logic [2:0]        r_waddr0;
    logic [2:0]        r_waddr1;
    logic [DATA_W-1:0] r_wdata0;
    logic [DATA_W-1:0] r_wdata1;
    logic [DATA_W-1:0] r_commit_pc;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [2:0]         w_n_req;
    logic [2:0]         w_n_grant;
    logic [PTR_W:0]     w_free;
    logic               w_grant;

    logic [PTR_W-1:0]   w_slot_idx  [c_SLOTS];
    logic [2:0]         w_slot_wreg [c_SLOTS];
    logic [DATA_W-1:0]  w_slot_pc   [c_SLOTS];

    logic [c_FWD_W-1:0] w_fwd     [c_SLOTS];
    logic               w_fwd_hit [c_SLOTS];
    logic [PTR_W-1:0]   w_fwd_idx [c_SLOTS];
    logic [DATA_W-1:0]  w_fwd_val [c_SLOTS];

    logic [PTR_W-1:0]   w_head1;
    logic               w_r0;
    logic               w_r1;
    logic               w_same_dest;
    logic [1:0]         w_n_ret;

    assign w_fwd[0] = fwd_a;
    assign w_fwd[1] = fwd_b;
    assign w_fwd[2] = fwd_c;
    assign w_fwd[3] = fwd_d;

    // Slot A sits in the most significant field of the packed slot vectors.
    for (genvar k = 0; k < c_SLOTS; k++) begin : g_slot
        assign w_slot_idx[k]  = r_tail + PTR_W'(k);
        assign w_slot_wreg[k] = alloc_wreg[11-3*k -: 3];
        assign w_slot_pc[k]   = alloc_pc[(c_SLOTS-k)*DATA_W-1 -: DATA_W];
    end

    for (genvar b = 0; b < c_SLOTS; b++) begin : g_fwd
        assign w_fwd_idx[b] = w_fwd[b][DATA_W +: PTR_W];
        assign w_fwd_val[b] = w_fwd[b][DATA_W-1:0];
        assign w_fwd_hit[b] = w_fwd[b][c_FWD_W-1] && r_valid[w_fwd_idx[b]];
    end

    assign w_n_req = {2'b00, alloc_req[0]} + {2'b00, alloc_req[1]}
                   + {2'b00, alloc_req[2]} + {2'b00, alloc_req[3]};

    // Free space deliberately ignores entries retiring this same cycle.
    assign w_free    = c_DEPTH - r_count;
    assign w_grant   = (w_n_req != 3'd0)
                    && (w_free >= {{(PTR_W-2){1'b0}}, w_n_req})
                    && !flush;
    assign w_n_grant = w_grant ? w_n_req : 3'd0;

    assign w_head1 = r_head + PTR_W'(1);
    assign w_r0    = !flush && r_valid[r_head] && r_ready[r_head];
    assign w_r1    = w_r0 && r_valid[w_head1] && r_ready[w_head1];
    assign w_n_ret = {1'b0, w_r0} + {1'b0, w_r1};

    // Two retirements to one register: only the younger write survives.
    assign w_same_dest = w_r1 && r_ent_wen[r_head] && r_ent_wen[w_head1]
                      && (r_ent_wreg[r_head] == r_ent_wreg[w_head1]);

    // ------------------------------------------------------------------
    // Entry valid / ready bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_ready <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_ready <= '0;
        end else begin
            for (int b = 0; b < c_SLOTS; b++) begin
                if (w_fwd_hit[b]) begin
                    r_ready[w_fwd_idx[b]] <= 1'b1;
                end
            end
            if (w_r0) begin
                r_valid[r_head] <= 1'b0;
                r_ready[r_head] <= 1'b0;
            end
            if (w_r1) begin
                r_valid[w_head1] <= 1'b0;
                r_ready[w_head1] <= 1'b0;
            end
            if (w_grant) begin
                for (int k = 0; k < c_SLOTS; k++) begin
                    if (alloc_req[k]) begin
                        r_valid[w_slot_idx[k]] <= 1'b1;
                        r_ready[w_slot_idx[k]] <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry payload; only meaningful while the matching valid bit is set
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!flush) begin
            // Later buses overwrite earlier ones, so bus D wins a collision.
            for (int b = 0; b < c_SLOTS; b++) begin
                if (w_fwd_hit[b]) begin
                    r_ent_value[w_fwd_idx[b]] <= w_fwd_val[b];
                end
            end
            if (w_grant) begin
                for (int k = 0; k < c_SLOTS; k++) begin
                    if (alloc_req[k]) begin
                        r_ent_wen[w_slot_idx[k]]  <= alloc_wen[k];
                        r_ent_wreg[w_slot_idx[k]] <= w_slot_wreg[k];
                        r_ent_pc[w_slot_idx[k]]   <= w_slot_pc[k];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_n_ret);
            r_tail  <= r_tail + PTR_W'(w_n_grant);
            r_count <= r_count + (PTR_W+1)'(w_n_grant) - (PTR_W+1)'(w_n_ret);
        end
    end

    // ------------------------------------------------------------------
    // Register-file write ports
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen0      <= 1'b0;
            r_wen1      <= 1'b0;
            r_waddr0    <= '0;
            r_waddr1    <= '0;
            r_wdata0    <= '0;
            r_wdata1    <= '0;
            r_commit_pc <= '0;
        end else begin
            r_wen0 <= w_r0 && r_ent_wen[r_head] && !w_same_dest;
            r_wen1 <= w_r1 && r_ent_wen[w_head1];
            if (w_r0) begin
                r_waddr0 <= r_ent_wreg[r_head];
                r_wdata0 <= r_ent_value[r_head];
            end
            if (w_r1) begin
                r_waddr1    <= r_ent_wreg[w_head1];
                r_wdata1    <= r_ent_value[w_head1];
                r_commit_pc <= r_ent_pc[w_head1];
            end else if (w_r0) begin
                r_commit_pc <= r_ent_pc[r_head];
            end
        end
    end

`ifdef COMMIT_STATS_EN
    logic [31:0] r_retired_total;

    // Survives flush; only the hard reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired_total <= '0;
        end else begin
            r_retired_total <= r_retired_total + 32'(w_n_ret);
        end
    end

    assign retired_total = r_retired_total;
`endif

    assign alloc_grant = w_grant;
    assign alloc_base  = r_tail;
    assign wen0        = r_wen0;
    assign wen1        = r_wen1;
    assign waddr0      = r_waddr0;
    assign waddr1      = r_waddr1;
    assign wdata0      = r_wdata0;
    assign wdata1      = r_wdata1;
    assign commit_pc   = r_commit_pc;
    assign rob_count   = r_count;
    assign rob_empty   = (r_count == '0);

endmodule

`default_nettype wire
